// File: rtl/ssd_scan.sv
// Four-digit common-anode seven-segment scanner: refresh prescaler, digit-scan index,
// hex-to-segment decode and leading-zero blanking, all display pins registered.
module ssd_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_W       = 17,
    parameter int BLANK_LZ    = 1
) (
    input  logic        ssd_clk,
    input  logic        ssd_rst,
    input  logic        ssd_en,
    input  logic [15:0] ssd_digits,
    input  logic [3:0]  ssd_dp_in,
    output logic [3:0]  ssd_an,
    output logic [6:0]  ssd_seg,
    output logic        ssd_dp
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic             tick;
    logic [3:0]       dig;
    logic [3:0]       zero;
    logic [3:0]       lead_zero;
    logic             blank_slot;
    logic [3:0]       an_p0;
    logic [6:0]       seg_p0;
    logic             dp_p0;

    assign tick = (div_cnt == DIV_LAST) && ssd_en;

    // Stage p0: decode the slot selected by idx from the live inputs
    always_comb begin
        zero         = 4'b0000;
        lead_zero    = 4'b0000;
        dig          = ssd_digits[{idx, 2'b00} +: 4];
        for (int k = 0; k < 4; k++) begin
            zero[k] = (ssd_digits[4*k +: 4] == 4'h0);
        end
        // Digit 0 always shows, even when the whole value is zero
        lead_zero[3] = zero[3];
        lead_zero[2] = zero[3] & zero[2];
        lead_zero[1] = zero[3] & zero[2] & zero[1];
        blank_slot   = (BLANK_LZ != 0) && lead_zero[idx];
        an_p0        = 4'b1111;
        seg_p0       = 7'h7F;
        dp_p0        = 1'b1;
        if (ssd_en && !blank_slot) begin
            an_p0  = ~(4'b0001 << idx);
            seg_p0 = hex_to_seg(dig);
            dp_p0  = ~ssd_dp_in[idx];
        end
    end

    // Stage p1: scan state advance and registered display pins
    always_ff @(posedge ssd_clk or posedge ssd_rst) begin
        if (ssd_rst) begin
            div_cnt <= '0;
            idx     <= 2'd0;
            ssd_an  <= 4'b1111;
            ssd_seg <= 7'h7F;
            ssd_dp  <= 1'b1;
        end else begin
            if (ssd_en) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
            end
            if (tick) begin
                idx <= idx + 2'd1;
            end
            ssd_an  <= an_p0;
            ssd_seg <= seg_p0;
            ssd_dp  <= dp_p0;
        end
    end

endmodule

// File: tb/tb_ssd_scan.sv
// Directed bench for ssd_scan: two instances (blanking on/off) share stimulus and are
// checked each cycle against a queued reference plus spot checks on known slot values.
module tb_ssd_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [15:0] digits = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;

    always #5 clk = ~clk;

    ssd_scan #(.REFRESH_DIV(4), .DIV_W(3), .BLANK_LZ(1)) dut_a (
        .ssd_clk(clk), .ssd_rst(rst), .ssd_en(en), .ssd_digits(digits),
        .ssd_dp_in(dp_in), .ssd_an(an_a), .ssd_seg(seg_a), .ssd_dp(dp_a)
    );

    ssd_scan #(.REFRESH_DIV(4), .DIV_W(3), .BLANK_LZ(0)) dut_b (
        .ssd_clk(clk), .ssd_rst(rst), .ssd_en(en), .ssd_digits(digits),
        .ssd_dp_in(dp_in), .ssd_an(an_b), .ssd_seg(seg_b), .ssd_dp(dp_b)
    );

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] b;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   m_div = 0;
    int   m_idx = 0;

    localparam logic [11:0] DARK = 12'hFFF;

    function automatic logic [6:0] segtab(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    function automatic logic [11:0] mdl(input logic [15:0] d, input logic [3:0] dpr,
                                        input logic e, input int i, input bit lz);
        logic [15:0] hi;
        logic [3:0]  onehot;
        hi = d >> (4 * i);
        onehot = 4'b0001 << i;
        if (!e || (lz && i != 0 && hi == 16'h0)) return DARK;
        return {~onehot, segtab(hi[3:0]), ~dpr[i]};
    endfunction

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag);
        exp_t e;
        exp_t g;
        e.a = mdl(digits, dp_in, en, m_idx, 1'b1);
        e.b = mdl(digits, dp_in, en, m_idx, 1'b0);
        sbq.push_back(e);
        if (en) begin
            if (m_div == 3) begin
                m_div = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_div++;
            end
        end
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        chk({tag, "/lz1"}, {an_a, seg_a, dp_a}, g.a);
        chk({tag, "/lz0"}, {an_b, seg_b, dp_b}, g.b);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_a", {an_a, seg_a, dp_a}, DARK);
        chk("rst_async_b", {an_b, seg_b, dp_b}, DARK);
        @(posedge clk);
        #3;
        rst = 1'b0;
        m_div = 0;
        m_idx = 0;
        sbq.delete();
    endtask

    initial begin
        logic [6:0]  seg2 [4];
        logic [6:0]  seg3 [4];
        logic [3:0]  an_exp;
        int          n;

        seg2 = '{7'h19, 7'h30, 7'h24, 7'h79};
        seg3 = '{7'h40, 7'h12, 7'h7F, 7'h7F};

        #1 rst = 1'b1;
        #1;
        chk("reset_state", {an_a, seg_a, dp_a}, DARK);

        // Basic scan of 1234
        digits = 16'h1234;
        en = 1'b1;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                cyc("scan1234");
                an_exp = ~(4'b0001 << s);
                chk("scan_an", {8'h0, an_a}, {8'h0, an_exp});
                chk("scan_seg", {5'h0, seg_a}, {5'h0, seg2[s]});
            end
        end
        cyc("scan_wrap");
        chk("wrap_an", {8'h0, an_a}, 12'h00E);

        // Reset mid-slot, then a full first slot
        cyc("pre_rst");
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cyc("post_rst");
            chk("post_rst_an", {8'h0, an_a}, 12'h00E);
        end
        cyc("post_rst_next");
        chk("post_rst_next_an", {8'h0, an_a}, 12'h00D);

        // Leading-zero blanking of 0050
        digits = 16'h0050;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                cyc("lz0050");
                chk("lz_seg", {5'h0, seg_a}, {5'h0, seg3[s]});
            end
        end

        // All zero with dp request on digit 3
        digits = 16'h0000;
        dp_in = 4'b1000;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                cyc("zero_dp");
                chk("nolz_seg", {5'h0, seg_b}, 12'h040);
            end
        end

        // Enable drop in slot 2, clock 2
        digits = 16'h1234;
        dp_in = 4'b0000;
        do_reset();
        n = 0;
        while (!(m_idx == 2 && m_div == 2) && n < 32) begin
            cyc("en_align");
            n++;
        end
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc("en_off");
            chk("en_off_an", {8'h0, an_a}, 12'h00F);
        end
        en = 1'b1;
        cyc("en_resume");
        chk("resume_an0", {8'h0, an_a}, 12'h00B);
        cyc("en_resume");
        chk("resume_an1", {8'h0, an_a}, 12'h00B);
        cyc("en_resume");
        chk("resume_an2", {8'h0, an_a}, 12'h007);

        // Live digit change mid-slot 0
        digits = 16'h000A;
        do_reset();
        cyc("live_a");
        cyc("live_a");
        chk("live_seg_a", {5'h0, seg_a}, 12'h008);
        digits = 16'h000F;
        cyc("live_f");
        chk("live_seg_f", {5'h0, seg_a}, 12'h00E);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
